cpu_bus_clkgen: RTL and testbench
=================================

Name: cpu_bus_clkgen

Overview:
Generates the external CPU clock, CPU reset and READY wait-state signals from CORE_CLK for the 8088/Z80 bus sockets. It generalises the fixed power-of-two CPU clock divider in the top level. Period and high time are programmable at run time, with glitch-free updates applied only at period boundaries. It also adds a counted power-on/soft reset sequence and a wait-state READY generator. It sits between the AXI-side core clock domain and the CPU socket pins.

Parameters:
CNT_WIDTH, 8, width of period/high-time counters and config inputs
DEF_PERIOD, 20, CPU clock period in CORE_CLK cycles after reset (5 MHz from 100 MHz)
DEF_HIGH, 7, CPU clock high time in CORE_CLK cycles after reset (~33% duty, 8088 spec)
RESET_CLKS, 8, number of CPU clock falling edges CPU_RESET is held after reset/soft reset
WS_WIDTH, 4, width of wait-state count input

Ports:
CORE_CLK  in  1  core clock, all logic on rising edge
RESETN  in  1  asynchronous active-low reset
RUN  in  1  1 = CPU clock runs; 0 = stop low at next period boundary
CFG_PERIOD  in  CNT_WIDTH  requested period, core cycles
CFG_HIGH  in  CNT_WIDTH  requested high time, core cycles
CFG_LOAD  in  1  one-cycle strobe: capture CFG_* into pending shadow
CFG_PENDING  out  1  shadow config captured, not yet applied
SOFT_RESET  in  1  restart CPU reset sequence
BUS_START  in  1  one-cycle strobe per CPU bus cycle (synchronised ALE)
WAIT_CNT  in  WS_WIDTH  wait states to insert for this bus cycle
WAIT_EXT  in  1  external extend request; holds READY low while 1
CPU_CLK  out  1  registered CPU clock
CLK_RISE  out  1  registered strobe, high in the cycle CPU_CLK goes 0->1
CLK_FALL  out  1  registered strobe, high in the cycle CPU_CLK goes 1->0
CPU_RESET  out  1  active-high CPU reset
READY  out  1  CPU READY

Behaviour:
- Reset values: CPU_CLK=0, CLK_RISE=0, CLK_FALL=0, CPU_RESET=1, READY=1, CFG_PENDING=0.
- Reset state: active period/high = DEF_PERIOD/DEF_HIGH; phase counter ph=0; divider in STOPPED.
- All outputs are registered. No combinational path from inputs to outputs.

Divider states are STOPPED and RUNNING.
- STOPPED: CPU_CLK=0, no strobes. If RUN=1, next cycle enters RUNNING with ph=0, CPU_CLK=1, CLK_RISE=1.
- RUNNING: CPU_CLK=1 while ph<act_high, else 0. ph increments each cycle.
- Wrap: at ph=act_period-1, next ph=0.
- Boundary (cycle that would set ph=0):
  - if CFG_PENDING, load act_* from shadow and clear CFG_PENDING;
  - then if RUN=0, go to STOPPED (CPU_CLK stays 0);
  - else CPU_CLK rises with CLK_RISE=1.
- CLK_FALL=1 in the cycle ph reaches act_high.
- In STOPPED, a pending config is applied immediately (next cycle).

Config capture:
- On CFG_LOAD, clamp then capture into shadow and set CFG_PENDING:
  - period<2 -> 2;
  - high=0 -> 1;
  - high>=period -> period-1.
- CFG_LOAD while pending overwrites the shadow.
- CFG_LOAD in the same cycle as the boundary: the old shadow is applied, the new one stays pending.

Reset sequence:
- CPU_RESET=1 from reset. A counter counts CLK_FALL events.
- CPU_RESET is cleared on the same edge that produces the RESET_CLKS-th CLK_FALL.
- SOFT_RESET=1: next cycle CPU_RESET=1 and the counter is cleared. Counting resumes after SOFT_RESET returns to 0.
- SOFT_RESET has no effect on the divider.

READY generator:
- Idle: READY=1.
- BUS_START with WAIT_CNT=0 and WAIT_EXT=0: READY stays 1.
- Otherwise: next cycle READY=0 and wait counter=WAIT_CNT.
- Each CLK_FALL decrements the counter while it is >0.
- READY returns to 1 on the first CLK_FALL where the counter is already 0 (or becomes 0) and WAIT_EXT=0.
- BUS_START while READY=0 is ignored.
- CPU_RESET=1 forces READY=1 and clears the counter.
- Divider STOPPED: READY is frozen.

Test Plan:
- Defaults, RUN=1 one cycle after RESETN rise -> CPU_CLK pattern 7 high/13 low. CLK_RISE every 20 cycles. CPU_RESET falls exactly 147 core cycles after the first CLK_RISE (8th fall).
- Load CFG_PERIOD=6/CFG_HIGH=2 mid-period -> CFG_PENDING=1 until the boundary, current period completes at 20. Next periods are 2 high/4 low, with no runt pulse.
- CFG_PERIOD=1, CFG_HIGH=9 -> applied as period 2/high 1 (alternating CPU_CLK).
- RUN=0 at ph=3 -> period completes, CPU_CLK stays 0 with no strobes. RUN=1 -> CLK_RISE next cycle.
- After reset done, BUS_START with WAIT_CNT=2 and WAIT_EXT=0 -> READY=0 next cycle, returns to 1 on the 3rd CLK_FALL. Repeat with WAIT_EXT held for 5 periods -> READY=1 on the first CLK_FALL after WAIT_EXT drops.
- SOFT_RESET pulse during a wait -> CPU_RESET=1 and READY=1 next cycle. CPU_RESET clears after 8 more CLK_FALLs.

Source files
------------

// File: rtl/cpu_bus_clkgen.sv
// cpu_bus_clkgen: programmable CPU clock divider with glitch-free reconfiguration,
// counted CPU reset sequence and wait-state READY generation for the CPU socket.
module cpu_bus_clkgen #(
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned DEF_PERIOD = 20,
    parameter int unsigned DEF_HIGH   = 7,
    parameter int unsigned RESET_CLKS = 8,
    parameter int unsigned WS_WIDTH   = 4
) (
    input  logic                 i_core_clk,
    input  logic                 i_resetn,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_cfg_period,
    input  logic [CNT_WIDTH-1:0] i_cfg_high,
    input  logic                 i_cfg_load,
    output logic                 o_cfg_pending,
    input  logic                 i_soft_reset,
    input  logic                 i_bus_start,
    input  logic [WS_WIDTH-1:0]  i_wait_cnt,
    input  logic                 i_wait_ext,
    output logic                 o_cpu_clk,
    output logic                 o_clk_rise,
    output logic                 o_clk_fall,
    output logic                 o_cpu_reset,
    output logic                 o_ready
);

    localparam int unsigned RST_CNT_W = $clog2(RESET_CLKS + 2);

    typedef enum logic {
        S_STOPPED = 1'b0,
        S_RUNNING = 1'b1
    } div_state_t;

    div_state_t             r_state;
    logic [CNT_WIDTH-1:0]   r_ph;
    logic [CNT_WIDTH-1:0]   r_act_period;
    logic [CNT_WIDTH-1:0]   r_act_high;
    logic [CNT_WIDTH-1:0]   r_sh_period;
    logic [CNT_WIDTH-1:0]   r_sh_high;
    logic                   r_pending;
    logic                   r_cpu_clk;
    logic                   r_clk_rise;
    logic                   r_clk_fall;
    logic                   r_cpu_reset;
    logic [RST_CNT_W-1:0]   r_rst_cnt;
    logic                   r_ready;
    logic [WS_WIDTH-1:0]    r_wait_cnt;

    logic [CNT_WIDTH-1:0]   w_clamp_period;
    logic [CNT_WIDTH-1:0]   w_clamp_high;
    logic [CNT_WIDTH-1:0]   w_ph_inc;
    logic                   w_wrap;
    logic                   w_running;
    logic                   w_apply;
    logic                   w_fall_c;

    // Clamp requested config into a legal period (>=2) and high time (1..period-1)
    always_comb begin
        w_clamp_period = i_cfg_period;
        w_clamp_high   = i_cfg_high;
        if (i_cfg_period < CNT_WIDTH'(2)) begin
            w_clamp_period = CNT_WIDTH'(2);
        end
        if (i_cfg_high == '0) begin
            w_clamp_high = CNT_WIDTH'(1);
        end
        if (w_clamp_high >= w_clamp_period) begin
            w_clamp_high = w_clamp_period - CNT_WIDTH'(1);
        end
    end

    // Phase bookkeeping: wrap point, shadow apply point and the fall being produced this edge
    always_comb begin
        w_running = (r_state == S_RUNNING);
        w_ph_inc  = r_ph + CNT_WIDTH'(1);
        w_wrap    = (r_ph == r_act_period - CNT_WIDTH'(1));
        w_apply   = r_pending && (!w_running || w_wrap);
        // At the wrap the next phase is 0 and high time is >=1, so no fall there
        w_fall_c  = w_running && !w_wrap && (w_ph_inc == r_act_high);
    end

    // Divider FSM; config only changes at a period boundary or while stopped
    always_ff @(posedge i_core_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= S_STOPPED;
            r_ph         <= '0;
            r_act_period <= CNT_WIDTH'(DEF_PERIOD);
            r_act_high   <= CNT_WIDTH'(DEF_HIGH);
            r_sh_period  <= CNT_WIDTH'(DEF_PERIOD);
            r_sh_high    <= CNT_WIDTH'(DEF_HIGH);
            r_pending    <= 1'b0;
            r_cpu_clk    <= 1'b0;
            r_clk_rise   <= 1'b0;
            r_clk_fall   <= 1'b0;
        end else begin
            r_clk_rise <= 1'b0;
            r_clk_fall <= 1'b0;
            if (w_apply) begin
                r_act_period <= r_sh_period;
                r_act_high   <= r_sh_high;
            end
            // A load coinciding with an apply leaves the new values pending
            if (i_cfg_load) begin
                r_sh_period <= w_clamp_period;
                r_sh_high   <= w_clamp_high;
                r_pending   <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
            case (r_state)
                S_STOPPED: begin
                    r_cpu_clk <= 1'b0;
                    if (i_run) begin
                        r_state    <= S_RUNNING;
                        r_ph       <= '0;
                        r_cpu_clk  <= 1'b1;
                        r_clk_rise <= 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (w_wrap) begin
                        r_ph <= '0;
                        if (i_run) begin
                            r_cpu_clk  <= 1'b1;
                            r_clk_rise <= 1'b1;
                        end else begin
                            r_state   <= S_STOPPED;
                            r_cpu_clk <= 1'b0;
                        end
                    end else begin
                        r_ph       <= w_ph_inc;
                        r_cpu_clk  <= (w_ph_inc < r_act_high);
                        r_clk_fall <= w_fall_c;
                    end
                end
                default: begin
                    r_state   <= S_STOPPED;
                    r_cpu_clk <= 1'b0;
                end
            endcase
        end
    end

    // CPU reset sequence: held until the RESET_CLKS-th CPU clock fall
    always_ff @(posedge i_core_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cpu_reset <= 1'b1;
            r_rst_cnt   <= '0;
        end else if (i_soft_reset) begin
            r_cpu_reset <= 1'b1;
            r_rst_cnt   <= '0;
        end else if (r_cpu_reset && w_fall_c) begin
            if (r_rst_cnt == RST_CNT_W'(RESET_CLKS - 1)) begin
                r_cpu_reset <= 1'b0;
            end
            r_rst_cnt <= r_rst_cnt + RST_CNT_W'(1);
        end
    end

    // READY generator: WAIT_CNT falls hold READY low, it rises on the following fall
    always_ff @(posedge i_core_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ready    <= 1'b1;
            r_wait_cnt <= '0;
        end else if (i_soft_reset || r_cpu_reset) begin
            r_ready    <= 1'b1;
            r_wait_cnt <= '0;
        end else if (w_running) begin
            if (r_ready) begin
                if (i_bus_start && ((i_wait_cnt != '0) || i_wait_ext)) begin
                    r_ready    <= 1'b0;
                    r_wait_cnt <= i_wait_cnt;
                end
            end else if (w_fall_c) begin
                if (r_wait_cnt != '0) begin
                    r_wait_cnt <= r_wait_cnt - WS_WIDTH'(1);
                end else if (!i_wait_ext) begin
                    r_ready <= 1'b1;
                end
            end
        end
    end

    assign o_cfg_pending = r_pending;
    assign o_cpu_clk     = r_cpu_clk;
    assign o_clk_rise    = r_clk_rise;
    assign o_clk_fall    = r_clk_fall;
    assign o_cpu_reset   = r_cpu_reset;
    assign o_ready       = r_ready;

endmodule

// File: tb/tb_cpu_bus_clkgen.sv
// Bench for cpu_bus_clkgen: period/duty vectors, reconfiguration, stop/start,
// reset sequence and READY wait-state behaviour.
module tb_cpu_bus_clkgen;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [7:0] cfg_period;
    logic [7:0] cfg_high;
    logic       cfg_load;
    logic       cfg_pending;
    logic       soft_reset;
    logic       bus_start;
    logic [3:0] wait_cnt;
    logic       wait_ext;
    logic       cpu_clk;
    logic       clk_rise;
    logic       clk_fall;
    logic       cpu_reset;
    logic       ready;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] period;
        logic [7:0] high;
        int         exp_hi;
        int         exp_lo;
    } vec_t;

    typedef struct {
        int hi;
        int lo;
    } shape_t;

    vec_t   vecs[6];
    shape_t q_shape[$];
    int     q_falls[$];

    cpu_bus_clkgen dut (
        .i_core_clk   (clk),
        .i_resetn     (rst_n),
        .i_run        (run),
        .i_cfg_period (cfg_period),
        .i_cfg_high   (cfg_high),
        .i_cfg_load   (cfg_load),
        .o_cfg_pending(cfg_pending),
        .i_soft_reset (soft_reset),
        .i_bus_start  (bus_start),
        .i_wait_cnt   (wait_cnt),
        .i_wait_ext   (wait_ext),
        .o_cpu_clk    (cpu_clk),
        .o_clk_rise   (clk_rise),
        .o_clk_fall   (clk_fall),
        .o_cpu_reset  (cpu_reset),
        .o_ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_rise();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!clk_rise && n < 300);
        check("wait_rise", int'(clk_rise), 1);
    endtask

    // Starts on a rise sample; returns high and low lengths, ends on the next rise sample
    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (cpu_clk && hi < 300) begin
            hi++;
            tick();
        end
        check("fall_strobe", int'(clk_fall), 1);
        while (!clk_rise && lo < 300) begin
            lo++;
            tick();
        end
    endtask

    task automatic check_shape(input string name);
        int     hi;
        int     lo;
        shape_t e;
        measure(hi, lo);
        e = q_shape.pop_front();
        check({name, "_hi"}, hi, e.hi);
        check({name, "_lo"}, lo, e.lo);
    endtask

    // Counts falls from the next edge until READY returns high
    task automatic falls_until_ready(input string name);
        int n;
        int nf;
        n  = 0;
        nf = 0;
        do begin
            tick();
            n++;
            if (clk_fall) nf++;
        end while (!ready && n < 400);
        check({name, "_ready"}, int'(ready), 1);
        check({name, "_on_fall"}, int'(clk_fall), 1);
        check({name, "_falls"}, nf, q_falls.pop_front());
    endtask

    initial begin
        int t_rise;
        int n;
        int nf;
        int nr;
        int nh;

        vecs[0] = '{8'd1,  8'd9,  1, 1};
        vecs[1] = '{8'd10, 8'd3,  3, 7};
        vecs[2] = '{8'd5,  8'd0,  1, 4};
        vecs[3] = '{8'd4,  8'd4,  3, 1};
        vecs[4] = '{8'd0,  8'd0,  1, 1};
        vecs[5] = '{8'd9,  8'd20, 8, 1};

        rst_n      = 1'b0;
        run        = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_load   = 1'b0;
        soft_reset = 1'b0;
        bus_start  = 1'b0;
        wait_cnt   = '0;
        wait_ext   = 1'b0;
        repeat (3) tick();

        check("rst_cpu_clk", int'(cpu_clk), 0);
        check("rst_rise", int'(clk_rise), 0);
        check("rst_fall", int'(clk_fall), 0);
        check("rst_cpu_reset", int'(cpu_reset), 1);
        check("rst_ready", int'(ready), 1);
        check("rst_pending", int'(cfg_pending), 0);

        // Default divider 7 high / 13 low
        rst_n = 1'b1;
        tick();
        run = 1'b1;
        wait_rise();
        t_rise = cyc;
        check("first_rise_clk", int'(cpu_clk), 1);
        q_shape.push_back('{7, 13});
        q_shape.push_back('{7, 13});
        check_shape("def_p1");
        check_shape("def_p2");

        // Reset released with the 8th fall, 147 cycles after the first rise
        n = 0;
        while (cpu_reset && n < 400) begin
            tick();
            n++;
        end
        check("reset_done", int'(cpu_reset), 0);
        check("reset_on_fall", int'(clk_fall), 1);
        check("reset_latency", cyc - t_rise, 147);

        // Mid-period reconfiguration to 6/2 waits for the boundary
        wait_rise();
        repeat (3) tick();
        cfg_period = 8'd6;
        cfg_high   = 8'd2;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        check("midcfg_pending", int'(cfg_pending), 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!clk_rise && n < 100);
        check("midcfg_tail", n, 16);
        check("midcfg_applied", int'(cfg_pending), 0);
        q_shape.push_back('{2, 4});
        q_shape.push_back('{2, 4});
        check_shape("cfg62_p1");
        check_shape("cfg62_p2");

        // Clamp vectors: each loaded at a rise, checked one full period after application
        for (int i = 0; i < 6; i++) begin
            cfg_period = vecs[i].period;
            cfg_high   = vecs[i].high;
            cfg_load   = 1'b1;
            q_shape.push_back('{vecs[i].exp_hi, vecs[i].exp_lo});
            tick();
            cfg_load = 1'b0;
            check($sformatf("vec%0d_pending", i), int'(cfg_pending), 1);
            wait_rise();
            check_shape($sformatf("vec%0d", i));
        end

        // Stop at ph=3 of a 9/8 period: finish the period then stay low
        repeat (3) tick();
        run = 1'b0;
        nf  = 0;
        nr  = 0;
        nh  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (clk_fall) nf++;
            if (clk_rise) nr++;
            if (cpu_clk) nh++;
        end
        check("stop_falls", nf, 1);
        check("stop_rises", nr, 0);
        check("stop_high_cycles", nh, 4);
        check("stop_clk_low", int'(cpu_clk), 0);
        run = 1'b1;
        tick();
        check("restart_rise", int'(clk_rise), 1);
        check("restart_clk", int'(cpu_clk), 1);

        // Zero-wait bus cycle keeps READY high
        bus_start = 1'b1;
        wait_cnt  = 4'd0;
        wait_ext  = 1'b0;
        tick();
        bus_start = 1'b0;
        check("nowait_ready", int'(ready), 1);

        // Two wait states: READY rises on the third fall
        wait_rise();
        bus_start = 1'b1;
        wait_cnt  = 4'd2;
        q_falls.push_back(3);
        tick();
        bus_start = 1'b0;
        wait_cnt  = 4'd0;
        check("ws2_ready_low", int'(ready), 0);
        falls_until_ready("ws2");

        // External extend held five periods; READY rises on the first fall after release
        wait_rise();
        bus_start = 1'b1;
        wait_ext  = 1'b1;
        tick();
        bus_start = 1'b0;
        check("ext_ready_low", int'(ready), 0);
        repeat (5) wait_rise();
        check("ext_still_low", int'(ready), 0);
        wait_ext = 1'b0;
        q_falls.push_back(1);
        falls_until_ready("ext");

        // Soft reset during a wait forces reset and READY, then counts 8 falls again
        wait_rise();
        bus_start = 1'b1;
        wait_cnt  = 4'd5;
        tick();
        bus_start = 1'b0;
        wait_cnt  = 4'd0;
        check("sr_ready_low", int'(ready), 0);
        repeat (2) tick();
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        check("sr_cpu_reset", int'(cpu_reset), 1);
        check("sr_ready", int'(ready), 1);
        n  = 0;
        nf = 0;
        do begin
            tick();
            n++;
            if (clk_fall) nf++;
        end while (cpu_reset && n < 400);
        check("sr_done", int'(cpu_reset), 0);
        check("sr_on_fall", int'(clk_fall), 1);
        check("sr_falls", nf, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
